// File: rtl/mem_req_arbiter_pkg.sv
// mem_req_arbiter_pkg
//   Shared definitions for the memory request arbiter:
//   - arb_state_e : arbiter FSM state encoding (IDLE / ISSUE / WAIT)
//   - idx_width() : width of an index into a set of n requesters
//   No ports.
//   Configuration macro used by the arbiter files: ARB_ROUND_ROBIN_EN
//   (defined = round-robin selection, undefined = fixed priority).
package mem_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  // Never narrower than one bit, so a degenerate count still yields a legal vector.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_req_arbiter_arb_pick.sv
// arb_pick
//   Purely combinational winner selection among the valid requesters.
//   Configuration macro: ARB_ROUND_ROBIN_EN
//     defined   : first valid index scanning from ptr_i+1, wrapping mod NR_REQ
//     undefined : fixed priority, lowest valid index wins, ptr_i ignored
//   Ports:
//     req_valid_i  in   NR_REQ  per-requester valid
//     ptr_i        in   IDX_W   round-robin pointer (last winner)
//     grant_oh_o   out  NR_REQ  one-hot winner (zero when nobody is valid)
//     grant_idx_o  out  IDX_W   binary index of the winner
//     any_o        out  1       at least one requester is valid
module arb_pick #(
  parameter int NR_REQ = 2,
  parameter int IDX_W  = 1
) (
  input  logic [NR_REQ-1:0] req_valid_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NR_REQ-1:0] grant_oh_o,
  output logic [IDX_W-1:0]  grant_idx_o,
  output logic              any_o
);

  logic found;

`ifdef ARB_ROUND_ROBIN_EN
  int cand;

  // Scan offsets 1..NR_REQ from the pointer so the last winner is checked last.
  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = 0;
    for (int i = 1; i <= NR_REQ; i++) begin
      cand = (int'(ptr_i) + i) % NR_REQ;
      if (!found && req_valid_i[cand]) begin
        found             = 1'b1;
        grant_idx_o       = IDX_W'(cand);
        grant_oh_o[cand]  = 1'b1;
      end
    end
  end
`else
  logic unusedPtr;
  assign unusedPtr = ^ptr_i;

  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    for (int i = 0; i < NR_REQ; i++) begin
      if (!found && req_valid_i[i]) begin
        found          = 1'b1;
        grant_idx_o    = IDX_W'(i);
        grant_oh_o[i]  = 1'b1;
      end
    end
  end
`endif

  assign any_o = |req_valid_i;

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Shares one memory request port among NR_REQ requesters with a single
//   outstanding transaction. IDLE accepts one winner and latches its payload,
//   ISSUE presents it to memory until accepted, WAIT routes the response back.
//   Configuration macro: ARB_ROUND_ROBIN_EN (round-robin when defined,
//   fixed lowest-index priority otherwise).
//   Ports:
//     clk, rst                     clock, synchronous active-high reset
//     req_valid / req_ready        per-requester handshake, req_ready one-hot comb.
//     req_addr/wen/wdata/wstrb     flattened per-requester payload
//     rsp_valid / rsp_rdata        registered one-hot response pulse + shared data
//     mem_req_valid / ready        memory request handshake
//     mem_addr/wen/wdata/wstrb     registered memory payload
//     mem_rsp_valid / mem_rdata    memory response (single cycle, no backpressure)
//     busy                         arbiter not idle
//     grant_idx                    current / last granted requester
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter  int NR_REQ = 2,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int IDX_W  = idx_width(NR_REQ),
  localparam int STRB_W = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NR_REQ-1:0]        req_valid,
  output logic [NR_REQ-1:0]        req_ready,
  input  logic [NR_REQ*ADDR_W-1:0] req_addr,
  input  logic [NR_REQ-1:0]        req_wen,
  input  logic [NR_REQ*DATA_W-1:0] req_wdata,
  input  logic [NR_REQ*STRB_W-1:0] req_wstrb,
  output logic [NR_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_wen,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [STRB_W-1:0]        mem_wstrb,
  input  logic                     mem_rsp_valid,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     busy,
  output logic [IDX_W-1:0]         grant_idx
);

  arb_state_e state_q, state_d;

  logic [NR_REQ-1:0] pickOh;
  logic [IDX_W-1:0]  pickIdx;
  logic              pickAny;
  logic [IDX_W-1:0]  arbPtr;
  logic              accept;

  logic [ADDR_W-1:0] memAddr_q;
  logic              memWen_q;
  logic [DATA_W-1:0] memWdata_q;
  logic [STRB_W-1:0] memWstrb_q;
  logic [IDX_W-1:0]  grantIdx_q;
  logic [NR_REQ-1:0] rspValid_q;
  logic [DATA_W-1:0] rspRdata_q;

  arb_pick #(
    .NR_REQ (NR_REQ),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req_valid_i (req_valid),
    .ptr_i       (arbPtr),
    .grant_oh_o  (pickOh),
    .grant_idx_o (pickIdx),
    .any_o       (pickAny)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rrPtr_q;

  // Resetting to the last index makes requester 0 the first winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtr_q <= IDX_W'(NR_REQ - 1);
    end else if (accept) begin
      rrPtr_q <= pickIdx;
    end
  end

  assign arbPtr = rrPtr_q;
`else
  assign arbPtr = IDX_W'(NR_REQ - 1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Requests are only accepted in IDLE, so req_ready stays low for the whole
  // transaction; memory responses outside WAIT are ignored.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pickAny) begin
          req_ready = pickOh;
          accept    = 1'b1;
          state_d   = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (mem_req_ready) begin
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (mem_rsp_valid) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      memAddr_q  <= '0;
      memWen_q   <= 1'b0;
      memWdata_q <= '0;
      memWstrb_q <= '0;
      grantIdx_q <= '0;
    end else if (accept) begin
      memAddr_q  <= req_addr[int'(pickIdx)*ADDR_W +: ADDR_W];
      memWen_q   <= req_wen[pickIdx];
      memWdata_q <= req_wdata[int'(pickIdx)*DATA_W +: DATA_W];
      memWstrb_q <= req_wstrb[int'(pickIdx)*STRB_W +: STRB_W];
      grantIdx_q <= pickIdx;
    end
  end

  // Writes also get a response pulse so every requester sees completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      rspValid_q <= '0;
      rspRdata_q <= '0;
    end else begin
      rspValid_q <= '0;
      if (state_q == ARB_WAIT && mem_rsp_valid) begin
        rspValid_q[grantIdx_q] <= 1'b1;
        rspRdata_q             <= mem_rdata;
      end
    end
  end

  assign mem_req_valid = (state_q == ARB_ISSUE);
  assign busy          = (state_q != ARB_IDLE);
  assign mem_addr      = memAddr_q;
  assign mem_wen       = memWen_q;
  assign mem_wdata     = memWdata_q;
  assign mem_wstrb     = memWstrb_q;
  assign grant_idx     = grantIdx_q;
  assign rsp_valid     = rspValid_q;
  assign rsp_rdata     = rspRdata_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter
//   Self-checking bench for mem_req_arbiter (NR_REQ=2, 32-bit address/data).
//   Expected responses are queued at request acceptance and compared when the
//   arbiter pulses rsp_valid. Honours ARB_ROUND_ROBIN_EN for the grant order.
module tb_mem_req_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_addr;
  logic [1:0]  req_wen;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        busy;
  logic [0:0]  grant_idx;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } rsp_t;

  rsp_t        sbQ[$];
  logic [31:0] addrTab  [2];
  logic        wenTab   [2];
  logic [31:0] wdataTab [2];
  logic [3:0]  wstrbTab [2];

  int compareCount  = 0;
  int mismatchCount = 0;

  mem_req_arbiter #(
    .NR_REQ (2),
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_wen       (req_wen),
    .req_wdata     (req_wdata),
    .req_wstrb     (req_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .busy          (busy),
    .grant_idx     (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request on requester n and remember its payload for checking.
  task automatic applyStimulus(input int n, input logic [31:0] a, input logic w,
                               input logic [31:0] d, input logic [3:0] s);
    addrTab[n]              = a;
    wenTab[n]               = w;
    wdataTab[n]             = d;
    wstrbTab[n]             = s;
    req_addr[n*32 +: 32]    = a;
    req_wen[n]              = w;
    req_wdata[n*32 +: 32]   = d;
    req_wstrb[n*4 +: 4]     = s;
    req_valid[n]            = 1'b1;
  endtask

  task automatic doReset();
    rst           = 1'b1;
    req_valid     = '0;
    req_addr      = '0;
    req_wen       = '0;
    req_wdata     = '0;
    req_wstrb     = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One complete transaction starting in IDLE with requests already driven.
  // Returns one cycle after the memory response, when rsp_valid pulses.
  task automatic runTxn(input int expIdx, input logic [31:0] rdata, input int readyDelay,
                        input bit spurious, input bit keepValid);
    rsp_t e;
    #1;
    checkOutput("acceptReady", req_ready, 64'd1 << expIdx);
    e.idx  = expIdx;
    e.data = rdata;
    sbQ.push_back(e);
    tick();
    if (!keepValid) req_valid[expIdx] = 1'b0;
    checkOutput("issueValid", mem_req_valid, 1);
    checkOutput("issueNoReady", req_ready, 0);
    checkOutput("grantIdx", grant_idx, expIdx);
    checkOutput("memAddr", mem_addr, addrTab[expIdx]);
    checkOutput("memWen", mem_wen, wenTab[expIdx]);
    checkOutput("memWdata", mem_wdata, wdataTab[expIdx]);
    checkOutput("memWstrb", mem_wstrb, wstrbTab[expIdx]);
    for (int c = 0; c < readyDelay; c++) begin
      mem_rsp_valid = spurious && (c == 1);
      mem_rdata     = 32'hBAD0_0000 + c;
      tick();
      mem_rsp_valid = 1'b0;
      checkOutput("holdValid", mem_req_valid, 1);
      checkOutput("holdAddr", mem_addr, addrTab[expIdx]);
      checkOutput("holdWdata", mem_wdata, wdataTab[expIdx]);
      checkOutput("holdWstrb", mem_wstrb, wstrbTab[expIdx]);
      checkOutput("holdNoReady", req_ready, 0);
      checkOutput("holdNoRsp", rsp_valid, 0);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    checkOutput("waitNoValid", mem_req_valid, 0);
    checkOutput("waitBusy", busy, 1);
    mem_rsp_valid = 1'b1;
    mem_rdata     = rdata;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    checkOutput("doneIdle", busy, 0);
  endtask

  // Response monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin : rspMonitor
    rsp_t e;
    if (rsp_valid != '0) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedRsp", rsp_valid, 0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("rspValid", rsp_valid, 64'd1 << e.idx);
        checkOutput("rspRdata", rsp_rdata, e.data);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rrOrder [4];
    int fpOrder [4];
    rrOrder = '{0, 1, 0, 1};
    fpOrder = '{0, 0, 0, 0};

    doReset();
    checkOutput("rstReqReady", req_ready, 0);
    checkOutput("rstRspValid", rsp_valid, 0);
    checkOutput("rstMemValid", mem_req_valid, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstMemAddr", mem_addr, 0);
    checkOutput("rstMemWdata", mem_wdata, 0);
    checkOutput("rstMemWstrb", mem_wstrb, 0);
    checkOutput("rstMemWen", mem_wen, 0);
    checkOutput("rstRdata", rsp_rdata, 0);
    checkOutput("rstGrant", grant_idx, 0);

    // Stray memory response while idle must be ignored.
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h5555_AAAA;
    tick();
    mem_rsp_valid = 1'b0;
    tick();
    checkOutput("idleSpurBusy", busy, 0);
    checkOutput("idleSpurMem", mem_req_valid, 0);
    checkOutput("idleSpurRsp", rsp_valid, 0);

    $display("[TB] single read");
    applyStimulus(0, 32'h8000_0000, 1'b0, 32'h0, 4'h0);
    runTxn(0, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);

    $display("[TB] write from requester 1");
    applyStimulus(1, 32'h4000_0010, 1'b1, 32'h1234_5678, 4'h3);
    runTxn(1, 32'h0000_0000, 0, 1'b0, 1'b0);

    $display("[TB] backpressure with stray response in ISSUE");
    applyStimulus(0, 32'h1000_0040, 1'b1, 32'hCAFE_F00D, 4'hF);
    runTxn(0, 32'h0BAD_CAFE, 5, 1'b1, 1'b0);

    $display("[TB] contention");
    doReset();
    applyStimulus(0, 32'hA000_0000, 1'b0, 32'h0, 4'h0);
    applyStimulus(1, 32'hB000_0000, 1'b1, 32'h7777_8888, 4'hC);
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      runTxn(rrOrder[k], 32'h0100_0000 + k, 0, 1'b0, 1'b1);
`else
      runTxn(fpOrder[k], 32'h0100_0000 + k, 0, 1'b0, 1'b1);
`endif
    end
    req_valid = '0;
    tick();

    $display("[TB] reset during WAIT");
    applyStimulus(1, 32'h2000_0004, 1'b0, 32'h0, 4'h0);
    #1;
    checkOutput("t5Ready", req_ready, 2'b10);
    tick();
    req_valid[1]  = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    checkOutput("t5WaitBusy", busy, 1);
    checkOutput("t5WaitGrant", grant_idx, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t5RstBusy", busy, 0);
    checkOutput("t5RstGrant", grant_idx, 0);
    checkOutput("t5RstMemValid", mem_req_valid, 0);
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h0F0F_0F0F;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    tick();
    checkOutput("t5NoRsp", rsp_valid, 0);
    checkOutput("t5StillIdle", busy, 0);
    applyStimulus(0, 32'h3000_0000, 1'b0, 32'h0, 4'h0);
    applyStimulus(1, 32'h3100_0000, 1'b0, 32'h0, 4'h0);
    runTxn(0, 32'h6666_0000, 0, 1'b0, 1'b0);
    req_valid = '0;

    tick();
    tick();
    checkOutput("scoreboardEmpty", sbQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
